// File: rtl/id_ex_bubble_reg_pkg.sv
// Shared ID/EX pipeline types: decoded control bundle, ALUOp encodings, stage actions.
// Pure declarations, no state; no flow control involved.
// Imported by id_ex_bubble_reg and its testbench.
package id_ex_bubble_reg_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam int BUBBLE_CNT_W = 16;

    // What the register does on a given edge, already priority-resolved.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    function automatic stage_act_e pick_action(input logic flush,
                                               input logic hold,
                                               input logic no_op);
        stage_act_e act;
        if (flush)      act = ACT_FLUSH;
        else if (hold)  act = ACT_HOLD;
        else if (no_op) act = ACT_BUBBLE;
        else            act = ACT_LOAD;
        return act;
    endfunction

endpackage

// File: rtl/id_ex_bubble_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Latency: count reflects an increment one cycle after inc.
// No backpressure; inc is sampled every edge.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_bubble_reg.sv
// ID/EX pipeline register with bubble insertion, branch flush and EX hold; optional bubble counter under ID_EX_PERF_CNT_EN.
// Latency: one cycle ID->EX, all outputs registered.
// Backpressure: hold freezes every field; priority flush > hold > no_op > load.
module id_ex_bubble_reg
    import id_ex_bubble_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              no_op,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

    stage_act_e        act;

    logic              nxt_valid;
    ctrl_t             nxt_ctrl;
    logic [DATA_W-1:0] nxt_rd1;
    logic [DATA_W-1:0] nxt_rd2;
    logic [DATA_W-1:0] nxt_imm;
    logic [DATA_W-1:0] nxt_pc4;
    logic [REG_W-1:0]  nxt_rs;
    logic [REG_W-1:0]  nxt_rt;
    logic [REG_W-1:0]  nxt_rd;

    assign act = pick_action(flush, hold, no_op);

    always_comb begin
        nxt_valid = ex_valid;
        nxt_ctrl  = ex_ctrl;
        nxt_rd1   = ex_rd1;
        nxt_rd2   = ex_rd2;
        nxt_imm   = ex_imm;
        nxt_pc4   = ex_pc4;
        nxt_rs    = ex_rs;
        nxt_rt    = ex_rt;
        nxt_rd    = ex_rd;
        unique case (act)
            ACT_FLUSH: begin
                // Killed slot: controls off, datapath simply follows ID.
                nxt_valid = 1'b0;
                nxt_ctrl  = CTRL_BUBBLE;
                nxt_rd1   = id_rd1;
                nxt_rd2   = id_rd2;
                nxt_imm   = id_imm;
                nxt_pc4   = id_pc4;
                nxt_rs    = id_rs;
                nxt_rt    = id_rt;
                nxt_rd    = id_rd;
            end
            ACT_HOLD: begin
                nxt_valid = ex_valid;
            end
            ACT_BUBBLE: begin
                // Zeroed specifiers keep forwarding and load-use compares from matching a bubble.
                nxt_valid = 1'b0;
                nxt_ctrl  = CTRL_BUBBLE;
                nxt_rd1   = id_rd1;
                nxt_rd2   = id_rd2;
                nxt_imm   = id_imm;
                nxt_pc4   = id_pc4;
                nxt_rs    = '0;
                nxt_rt    = '0;
                nxt_rd    = '0;
            end
            default: begin
                nxt_valid = id_valid;
                nxt_ctrl  = id_valid ? id_ctrl : CTRL_BUBBLE;
                nxt_rd1   = id_rd1;
                nxt_rd2   = id_rd2;
                nxt_imm   = id_imm;
                nxt_pc4   = id_pc4;
                nxt_rs    = id_rs;
                nxt_rt    = id_rt;
                nxt_rd    = id_rd;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_pc4   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= nxt_valid;
            ex_ctrl  <= nxt_ctrl;
            ex_rd1   <= nxt_rd1;
            ex_rd2   <= nxt_rd2;
            ex_imm   <= nxt_imm;
            ex_pc4   <= nxt_pc4;
            ex_rs    <= nxt_rs;
            ex_rt    <= nxt_rt;
            ex_rd    <= nxt_rd;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic bubble_ins;

    assign bubble_ins = (act == ACT_BUBBLE);

    sat_counter #(
        .W(BUBBLE_CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_ins),
        .count (bubble_cnt)
    );
`endif

endmodule
